// File: rtl/wb_bram_ctrl.sv
// Wishbone classic slave in front of a single-port BRAM with separate read/write latencies,
// byte-lane writes, address-window decode (err on miss) and abort when the master drops cyc.
module wb_bram_ctrl #(
    parameter int          DW          = 32,
    parameter int          MEM_AW      = 10,
    parameter int          READ_DELAY  = 10,
    parameter int          WRITE_DELAY = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h3800_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFC0_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [MEM_AW-1:0] bram_addr,
    output logic [DW-1:0]     bram_di,
    input  logic [DW-1:0]     bram_do
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    // The counter covers the D-1 WAIT cycles, so it starts at D-2 and exits at zero.
    localparam logic [3:0] RD_LOAD = 4'(READ_DELAY - 2);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_DELAY - 2);

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic              hit;
    logic              in_wait;

    assign hit     = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
    assign in_wait = (state_q == S_WAIT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE: begin
                if (wbs_cyc_i && wbs_stb_i) begin
                    if (hit) begin
                        state_d = S_WAIT;
                        we_d    = wbs_we_i;
                        sel_d   = wbs_sel_i;
                        addr_d  = wbs_adr_i[MEM_AW+1:2];
                        dat_d   = wbs_dat_i;
                        cnt_d   = wbs_we_i ? WR_LOAD : RD_LOAD;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            addr_q  <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
        end
    end

    // Outputs are gated by reset and cyc so an abort in the write cycle never reaches the BRAM.
    assign wbs_ack_o = wb_rst_n_i && (state_q == S_ACK);
    assign wbs_err_o = wb_rst_n_i && (state_q == S_ERR);
    assign wbs_dat_o = (wbs_ack_o && !we_q) ? bram_do : '0;
    assign bram_en   = wb_rst_n_i && in_wait;
    assign bram_we   = (wb_rst_n_i && in_wait && wbs_cyc_i && we_q && (cnt_q == 4'd0)) ? sel_q : 4'd0;
    assign bram_addr = addr_q;
    assign bram_di   = dat_q;

endmodule

// File: tb/tb_wb_bram_ctrl.sv
// Bench for wb_bram_ctrl: two instances (default delays, and read=2/write=15) each with a BRAM model.
module tb_wb_bram_ctrl;

    localparam logic [31:0] BASE = 32'h3800_0000;
    localparam logic [31:0] MASK = 32'hFFC0_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clr;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [3:0]  sel [2];
    logic [31:0] adr [2];
    logic [31:0] wdat[2];
    logic        ack [2];
    logic        err [2];
    logic [31:0] rdat[2];
    logic        b_en[2];
    logic [3:0]  b_we[2];
    logic [9:0]  b_addr[2];
    logic [31:0] b_di[2];
    logic [31:0] b_do[2];

    logic [31:0] bmem    [2][1024];
    logic [31:0] ref_mem [2][1024];

    int checks = 0;
    int failures = 0;

    wb_bram_ctrl #(.READ_DELAY(10), .WRITE_DELAY(10)) u0 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
        .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]),
        .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .wbs_dat_o(rdat[0]),
        .bram_en(b_en[0]), .bram_we(b_we[0]), .bram_addr(b_addr[0]), .bram_di(b_di[0]),
        .bram_do(b_do[0])
    );

    wb_bram_ctrl #(.READ_DELAY(2), .WRITE_DELAY(15)) u1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
        .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]),
        .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .wbs_dat_o(rdat[1]),
        .bram_en(b_en[1]), .bram_we(b_we[1]), .bram_addr(b_addr[1]), .bram_di(b_di[1]),
        .bram_do(b_do[1])
    );

    // Single-port BRAM with byte enables and one-cycle registered read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                for (int i = 0; i < 1024; i++) bmem[k][i] <= 32'h0;
                b_do[k] <= 32'h0;
            end else if (b_en[k]) begin
                for (int b = 0; b < 4; b++)
                    if (b_we[k][b]) bmem[k][b_addr[k]][8*b +: 8] <= b_di[k][8*b +: 8];
                b_do[k] <= bmem[k][b_addr[k]];
            end
        end
    end

    typedef struct {
        int          ack_c;
        int          err_c;
        logic [31:0] rd;
        int          we_c;
        int          we_n;
        logic [3:0]  we_v;
        logic [9:0]  we_a;
        int          en_n;
        int          dat_bad;
        int          both;
    } res_t;

    typedef struct {
        int          k;
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        miss;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int dly(input int k, input logic w);
        if (w) return (k == 1) ? 15 : 10;
        return (k == 1) ? 2 : 10;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Cycle n counts from the cycle the request is first presented (n=0).
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input int drop_at, input int rst_at, output res_t r);
        int stop;
        r = '{ack_c: -1, err_c: -1, rd: 32'h0, we_c: -1, we_n: 0, we_v: 4'h0, we_a: 10'h0,
              en_n: 0, dat_bad: 0, both: 0};
        stop = 30;
        @(posedge clk); #1;
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; wdat[k] = d;
        for (int n = 0; n < stop; n++) begin
            if (n == drop_at || (rst_at >= 0 && n == rst_at + 1)) begin
                cyc[k] = 1'b0; stb[k] = 1'b0;
            end
            if (n == rst_at) rst_n = 1'b0;
            if (rst_at >= 0 && n == rst_at + 2) rst_n = 1'b1;
            @(negedge clk);
            if (ack[k]) begin
                r.ack_c = (r.ack_c < 0) ? n : -2;
                r.rd = rdat[k];
            end
            if (err[k]) r.err_c = (r.err_c < 0) ? n : -2;
            if (ack[k] && err[k]) r.both++;
            if (b_we[k] != 4'h0) begin
                r.we_n++; r.we_c = n; r.we_v = b_we[k]; r.we_a = b_addr[k];
            end
            if (b_en[k]) r.en_n++;
            if ((!ack[k] || w) && rdat[k] != 32'h0) r.dat_bad++;
            @(posedge clk); #1;
            if ((ack[k] || err[k]) && stop == 30) begin
                cyc[k] = 1'b0; stb[k] = 1'b0;
                stop = n + 3;
            end
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
    endtask

    task automatic eval(input string t, input int k, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic miss, input logic [31:0] exp_rd, input res_t r);
        if (miss) begin
            chk({t, " err_cycle"}, r.err_c, 32'd1);
            chk({t, " no_ack"}, r.ack_c, 32'hFFFF_FFFF);
            chk({t, " no_bram_en"}, r.en_n, 32'd0);
        end else begin
            chk({t, " ack_cycle"}, r.ack_c, dly(k, w));
            chk({t, " no_err"}, r.err_c, 32'hFFFF_FFFF);
            if (w && s != 4'h0) begin
                chk({t, " we_cycle"}, r.we_c, dly(k, w) - 1);
                chk({t, " we_val"}, {28'h0, r.we_v}, {28'h0, s});
                chk({t, " we_addr"}, {22'h0, r.we_a}, {22'h0, a[11:2]});
            end
            if (!w) chk({t, " rdata"}, r.rd, exp_rd);
        end
        if (!w || s == 4'h0 || miss) chk({t, " we_count"}, r.we_n, (w && s != 4'h0 && !miss) ? 1 : 0);
        else chk({t, " we_count"}, r.we_n, 32'd1);
        chk({t, " ack_err_together"}, r.both, 32'd0);
        chk({t, " dat_o_zero"}, r.dat_bad, 32'd0);
    endtask

    vec_t vt[12];
    res_t r;
    int   mask;

    initial begin
        vt[0]  = '{0, 1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vt[1]  = '{0, 1'b0, 32'h3800_0010, 4'hF, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vt[2]  = '{0, 1'b1, 32'h3800_0020, 4'hF, 32'h1122_3344, 1'b0, 32'h0};
        vt[3]  = '{0, 1'b1, 32'h3800_0022, 4'h5, 32'hAABB_CCDD, 1'b0, 32'h0};
        vt[4]  = '{0, 1'b0, 32'h3800_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD};
        vt[5]  = '{0, 1'b0, 32'h3000_0000, 4'hF, 32'h0,         1'b1, 32'h0};
        vt[6]  = '{0, 1'b1, 32'h3800_0020, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'h0};
        vt[7]  = '{0, 1'b0, 32'h3800_0020, 4'hF, 32'h0,         1'b0, 32'h11BB_33DD};
        vt[8]  = '{1, 1'b1, 32'h3800_0000, 4'hF, 32'hCAFE_F00D, 1'b0, 32'h0};
        vt[9]  = '{1, 1'b0, 32'h3800_1000, 4'hF, 32'h0,         1'b0, 32'hCAFE_F00D};
        vt[10] = '{1, 1'b1, 32'h3840_0000, 4'hF, 32'h1234_5678, 1'b1, 32'h0};
        vt[11] = '{1, 1'b0, 32'h3800_0FFC, 4'hF, 32'h0,         1'b0, 32'h0};

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = 32'h0;
            cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = 1'b1; sel[k] = 4'hF;
            adr[k] = 32'h3800_0010; wdat[k] = 32'h5555_AAAA;
        end
        clr = 1'b1;
        rst_n = 1'b0;

        // Reset held with a live strobe: nothing may come out.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            clr = 1'b0;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst%0d_c%0d ack", k, c), {31'h0, ack[k]}, 32'h0);
                chk($sformatf("rst%0d_c%0d err", k, c), {31'h0, err[k]}, 32'h0);
                chk($sformatf("rst%0d_c%0d en", k, c), {31'h0, b_en[k]}, 32'h0);
                chk($sformatf("rst%0d_c%0d we", k, c), {28'h0, b_we[k]}, 32'h0);
                chk($sformatf("rst%0d_c%0d dat", k, c), rdat[k], 32'h0);
            end
        end
        for (int k = 0; k < 2; k++) begin cyc[k] = 1'b0; stb[k] = 1'b0; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst idle en", {31'h0, b_en[0] | b_en[1]}, 32'h0);
        chk("post_rst idle ack", {31'h0, ack[0] | ack[1] | err[0] | err[1]}, 32'h0);

        for (int i = 0; i < 12; i++) begin
            xfer(vt[i].k, vt[i].w, vt[i].a, vt[i].s, vt[i].d, -1, -1, r);
            eval($sformatf("vec%0d", i), vt[i].k, vt[i].w, vt[i].a, vt[i].s, vt[i].miss, vt[i].exp_rd, r);
            if (vt[i].w && !vt[i].miss)
                ref_mem[vt[i].k][vt[i].a[11:2]] = merge(ref_mem[vt[i].k][vt[i].a[11:2]], vt[i].d, vt[i].s);
        end

        // Master drops cyc mid-write.
        xfer(0, 1'b1, 32'h3800_0010, 4'hF, 32'h0BAD_0BAD, 5, -1, r);
        chk("abort no_ack", r.ack_c, 32'hFFFF_FFFF);
        chk("abort no_we", r.we_n, 32'd0);
        xfer(0, 1'b0, 32'h3800_0010, 4'hF, 32'h0, -1, -1, r);
        chk("abort old_value", r.rd, 32'hDEAD_BEEF);

        // Reset in the middle of a write.
        xfer(0, 1'b1, 32'h3800_0010, 4'hF, 32'h0BAD_F00D, -1, 4, r);
        chk("rst_abort no_ack", r.ack_c, 32'hFFFF_FFFF);
        chk("rst_abort no_we", r.we_n, 32'd0);
        xfer(0, 1'b0, 32'h3800_0010, 4'hF, 32'h0, -1, -1, r);
        chk("rst_abort old_value", r.rd, 32'hDEAD_BEEF);

        // Strobe held across ack: re-accepted the cycle after ack, acks at 2 and 5.
        mask = 0;
        @(posedge clk); #1;
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'hF; adr[1] = 32'h3800_0000;
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            if (ack[1]) begin
                mask |= (1 << n);
                chk($sformatf("b2b rdata n%0d", n), rdat[1], 32'hCAFE_F00D);
            end
            @(posedge clk); #1;
        end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        chk("b2b ack_cycles", mask, 32'h24);
        repeat (3) @(posedge clk);

        for (int i = 0; i < 80; i++) begin
            int          k;
            logic        w, miss;
            logic [3:0]  s;
            logic [31:0] a, d;
            k = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 7) == 0)
                a = 32'h4000_0000 | 32'($urandom_range(0, 4095));
            else
                a = BASE | (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 15)) << 2)
                         | 32'($urandom_range(0, 3));
            miss = ((a & MASK) != BASE);
            xfer(k, w, a, s, d, -1, -1, r);
            eval($sformatf("rnd%0d", i), k, w, a, s, miss, ref_mem[k][a[11:2]], r);
            if (w && !miss) ref_mem[k][a[11:2]] = merge(ref_mem[k][a[11:2]], d, s);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_bram_ctrl.md
Name: wb_bram_ctrl

Overview:
- Parametrised Wishbone classic slave that fronts a single-port user-area BRAM.
- Generalises the fixed-delay BRAM slave:
  - separate programmable read and write latencies
  - byte-lane write enables from wbs_sel_i
  - address-window decode with error response
  - abort on cycle drop
- Sits between the Caravel user_proj wishbone port and an external bram macro, whose ports are exposed.

Parameters:
- DW, 32, data width (must be 32).
- MEM_AW, 10, BRAM word-address width (depth = 2^MEM_AW words).
- READ_DELAY, 10, cycles from request acceptance to read ack; legal range 2..15.
- WRITE_DELAY, 10, cycles from request acceptance to write ack; legal range 2..15.
- BASE_ADDR, 32'h3800_0000, window base.
- ADDR_MASK, 32'hFFC0_0000, window compare mask.

Ports:
- wb_clk_i  in  1  clock; all logic is on the rising edge.
- wb_rst_n_i  in  1  synchronous, active-low reset.
- wbs_cyc_i  in  1  bus cycle.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer ack, one-cycle pulse.
- wbs_err_o  out  1  out-of-window error, one-cycle pulse.
- wbs_dat_o  out  32  read data; zero whenever wbs_ack_o=0 or the transfer is a write.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  MEM_AW  BRAM word address.
- bram_di  out  32  BRAM write data.
- bram_do  in  32  BRAM read data, 1-cycle registered latency.

Behaviour:
- Reset (wb_rst_n_i=0 at an edge):
  - state=IDLE, counter=0.
  - wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0.
  - bram_en=0, bram_we=0, bram_addr=0, bram_di=0.
  - Reset mid-transaction aborts the transaction: no ack, and no write if bram_we has not yet pulsed.
- hit = ((wbs_adr_i & ADDR_MASK) == BASE_ADDR).
- Word address = wbs_adr_i[MEM_AW+1:2]; bits [1:0] are ignored.
- States: IDLE, WAIT, ACK, ERR.
- IDLE: on cycle T with wbs_cyc_i & wbs_stb_i:
  - hit → WAIT. Latch we, sel, word address and data. Load counter = D-2, where D = READ_DELAY for a read or WRITE_DELAY for a write.
  - miss → ERR.
- WAIT:
  - bram_en=1 and bram_addr = latched address for every WAIT cycle.
  - Counter decrements each cycle. When counter==0 → ACK.
  - Write: bram_we = latched sel and bram_di = latched data in the last WAIT cycle (T+D-1) only; bram_we=0 in all other cycles.
  - Read: bram_do is sampled at the ACK cycle (valid, since the address was stable ≥1 cycle earlier).
  - If wbs_cyc_i=0 in any WAIT cycle → IDLE immediately. No ack, and no bram_we in that or later cycles.
- ACK (cycle T+D):
  - wbs_ack_o=1 for exactly one cycle.
  - wbs_dat_o = bram_do for a read, 0 for a write.
  - → IDLE.
- ERR (cycle T+1):
  - wbs_err_o=1 for exactly one cycle; wbs_ack_o=0; no BRAM access.
  - → IDLE.
- The earliest next acceptance is the cycle after ACK/ERR, giving a throughput of 1 transfer per D+1 cycles.
  - A strobe still held high in the IDLE cycle after ACK is treated as a new request (classic Wishbone; the master must drop stb on ack).
- wbs_sel_i=0 write: full latency, ack returned, bram_we stays 0, memory unchanged.
- A request arriving while the FSM is not IDLE is ignored until IDLE.
- wbs_ack_o and wbs_err_o are never high together.

Test Plan:
- Reset: hold wb_rst_n_i=0 for 3 cycles with stb asserted → ack, err, bram_en, bram_we and dat_o all 0; FSM remains IDLE.
- Write then read, default delays:
  - Write 0x3800_0010 ← 0xDEADBEEF, sel=4'hF → bram_we=4'hF at T+9 with bram_addr=4; ack at T+10.
  - Read of the same address → ack at T+10 with wbs_dat_o=0xDEADBEEF; dat_o=0 the cycle before and after.
- Byte lanes: preload 0x11223344; write 0xAABBCCDD with sel=4'b0101 → subsequent read returns 0x11BB33DD.
- Out of window: read 0x3000_0000 → wbs_err_o=1 at T+1, ack never asserts, bram_en stays 0.
- Abort: drop wbs_cyc_i at T+5 during a write → no ack, bram_we never pulses, and a later read of that address returns the old value.
- Parameter sweep: READ_DELAY=2, WRITE_DELAY=15, back-to-back transfers →
  - read ack at T+2 with correct data;
  - write ack at T+15;
  - next acceptance no earlier than ack+1;
  - word address wraps at 2^MEM_AW (0x3800_1000 maps to word 0).
